// File: rtl/dma_channel_scheduler_if.sv
// Channel-side and core-side signal bundle for the DMA channel scheduler.
// master = scheduler, slave = requesters plus DMA core.
interface dma_channel_scheduler_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]    ch_req;
  logic [32*NUM_CH-1:0] ch_src;
  logic [32*NUM_CH-1:0] ch_dst;
  logic [32*NUM_CH-1:0] ch_len;
  logic [NUM_CH-1:0]    ch_ack;
  logic [NUM_CH-1:0]    ch_done;
  logic [NUM_CH-1:0]    ch_err;
  logic                 busy;
  logic                 core_start;
  logic [31:0]          core_src;
  logic [31:0]          core_dst;
  logic [31:0]          core_len;
  logic                 core_done;
  logic                 core_clk_en;
  logic                 core_power_on;

  modport master (
    input  ch_req, ch_src, ch_dst, ch_len, core_done,
    output ch_ack, ch_done, ch_err, busy, core_start,
    output core_src, core_dst, core_len,
    output core_clk_en, core_power_on
  );

  modport slave (
    output ch_req, ch_src, ch_dst, ch_len, core_done,
    input  ch_ack, ch_done, ch_err, busy, core_start,
    input  core_src, core_dst, core_len,
    input  core_clk_en, core_power_on
  );
endinterface

// File: rtl/dma_channel_scheduler.sv
// Round-robin multi-channel front end for the single-channel DMA core,
// including core power sequencing, idle power-down and hang recovery.
module dma_channel_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int WAKE_CYCLES  = 4,
  parameter int IDLE_TIMEOUT = 256,
  parameter int WDOG_CYCLES  = 65536
) (
  input logic clk,
  input logic rst_n,
  dma_channel_scheduler_if.master bus
);

  localparam int PW = $clog2(NUM_CH);

  typedef enum logic [3:0] {
    S_OFF, S_WAKE, S_IDLE, S_ISSUE, S_RUN,
    S_COMPLETE, S_ZERO, S_REJECT, S_HUNG
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     g_q;
  logic [PW-1:0]     g_inc;
  logic [PW-1:0]     grant;
  logic [PW-1:0]     g_sel;
  logic              found;
  int unsigned       idx;
  logic [31:0]       sel_len;
  logic [31:0]       wake_cnt;
  logic [31:0]       idle_cnt;
  logic [31:0]       wdog_cnt;
  logic [NUM_CH-1:0] onehot;
  logic [NUM_CH-1:0] ack_d;
  logic [NUM_CH-1:0] done_d;
  logic [NUM_CH-1:0] err_d;
  logic              start_d;
  logic              power_d;
  logic              clk_en_d;
  logic              busy_d;

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && bus.ch_req[idx]) begin
        found = 1'b1;
        grant = PW'(idx);
      end
    end
  end

  assign sel_len = bus.ch_len[32*grant +: 32];
  assign g_inc   = (g_q == PW'(NUM_CH-1)) ? '0 : g_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_OFF;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_OFF:  if (|bus.ch_req) nxt = S_WAKE;
      S_WAKE: if (wake_cnt <= 32'd1) nxt = S_IDLE;
      S_IDLE: begin
        if (found) begin
          unique case (1'b1)
            sel_len == 32'd0:     nxt = S_ZERO;
            sel_len[1:0] != 2'd0: nxt = S_REJECT;
            default:              nxt = S_ISSUE;
          endcase
        end else if (IDLE_TIMEOUT != 0 &&
                     idle_cnt + 32'd1 == 32'(IDLE_TIMEOUT)) begin
          nxt = S_OFF;
        end
      end
      S_ISSUE: nxt = S_RUN;
      S_RUN: begin
        if (bus.core_done) nxt = S_COMPLETE;
        else if (wdog_cnt + 32'd1 == 32'(WDOG_CYCLES)) nxt = S_HUNG;
      end
      S_COMPLETE, S_ZERO, S_REJECT: nxt = S_IDLE;
      S_HUNG:  nxt = S_WAKE;
      default: nxt = S_OFF;
    endcase
  end

  // Outputs are decoded from the next state, then registered.
  always_comb begin
    g_sel         = (state == S_IDLE) ? grant : g_q;
    onehot        = '0;
    onehot[g_sel] = 1'b1;
    ack_d         = '0;
    done_d        = '0;
    err_d         = '0;
    start_d       = 1'b0;
    unique case (nxt)
      S_ISSUE:    begin start_d = 1'b1; ack_d = onehot; end
      S_ZERO:     begin ack_d = onehot; done_d = onehot; end
      S_REJECT:   begin ack_d = onehot; err_d = onehot; end
      S_COMPLETE: done_d = onehot;
      S_HUNG:     err_d = onehot;
      default:    ;
    endcase
    power_d  = !(nxt inside {S_OFF, S_HUNG});
    clk_en_d = !(nxt inside {S_OFF, S_WAKE, S_HUNG});
    busy_d   = !(nxt inside {S_OFF, S_IDLE});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr            <= '0;
      g_q               <= '0;
      wake_cnt          <= '0;
      idle_cnt          <= '0;
      wdog_cnt          <= '0;
      bus.ch_ack        <= '0;
      bus.ch_done       <= '0;
      bus.ch_err        <= '0;
      bus.busy          <= 1'b0;
      bus.core_start    <= 1'b0;
      bus.core_src      <= '0;
      bus.core_dst      <= '0;
      bus.core_len      <= '0;
      bus.core_clk_en   <= 1'b0;
      bus.core_power_on <= 1'b0;
    end else begin
      bus.ch_ack        <= ack_d;
      bus.ch_done       <= done_d;
      bus.ch_err        <= err_d;
      bus.busy          <= busy_d;
      bus.core_start    <= start_d;
      bus.core_clk_en   <= clk_en_d;
      bus.core_power_on <= power_d;
      if (state == S_IDLE && found) begin
        g_q          <= grant;
        bus.core_src <= bus.ch_src[32*grant +: 32];
        bus.core_dst <= bus.ch_dst[32*grant +: 32];
        bus.core_len <= sel_len;
      end
      if (state inside {S_COMPLETE, S_ZERO, S_REJECT, S_HUNG})
        rr_ptr <= g_inc;
      if (nxt == S_WAKE && state != S_WAKE)
        wake_cnt <= 32'(WAKE_CYCLES);
      else if (state == S_WAKE)
        wake_cnt <= wake_cnt - 32'd1;
      if (state == S_IDLE && !found && nxt == S_IDLE)
        idle_cnt <= idle_cnt + 32'd1;
      else
        idle_cnt <= '0;
      wdog_cnt <= (state == S_RUN) ? wdog_cnt + 32'd1 : '0;
    end
  end

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Self-checking bench for dma_channel_scheduler with a transaction-level
// round-robin model and randomized descriptors.
module tb_dma_channel_scheduler;

  localparam int NCH     = 4;
  localparam int WAKE    = 4;
  localparam int IDLE_TO = 8;
  localparam int WDOG    = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dma_channel_scheduler_if #(.NUM_CH(NCH)) bus ();

  dma_channel_scheduler #(
    .NUM_CH(NCH), .WAKE_CYCLES(WAKE),
    .IDLE_TIMEOUT(IDLE_TO), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int rr = 0;
  int n_ack = 0, n_start = 0, n_done = 0, n_err = 0;
  logic [31:0] srcs [NCH];
  logic [31:0] dsts [NCH];
  logic [31:0] lens [NCH];

  always @(negedge clk) begin
    n_ack   += $countones(bus.ch_ack);
    n_done  += $countones(bus.ch_done);
    n_err   += $countones(bus.ch_err);
    n_start += int'(bus.core_start);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int c, input logic [31:0] s,
                          input logic [31:0] d, input logic [31:0] l);
    bus.ch_src[32*c +: 32] = s;
    bus.ch_dst[32*c +: 32] = d;
    bus.ch_len[32*c +: 32] = l;
    srcs[c] = s;
    dsts[c] = d;
    lens[c] = l;
  endtask

  function automatic int model_grant(input logic [NCH-1:0] m, input int p);
    for (int k = 0; k < NCH; k++)
      if (m[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction

  function automatic logic [NCH-1:0] oh(input int c);
    logic [NCH-1:0] v;
    v = '0;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ch_req = '0;
    bus.core_done = 1'b0;
    bus.ch_src = '0;
    bus.ch_dst = '0;
    bus.ch_len = '0;
    repeat (2) tick();
    checks++;
    if ({bus.core_power_on, bus.core_clk_en, bus.busy, bus.core_start} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctl: got %b want 0000",
        {bus.core_power_on, bus.core_clk_en, bus.busy, bus.core_start});
    end
    checks++;
    if ({bus.ch_ack, bus.ch_done, bus.ch_err} !== '0) begin
      failures++;
      $display("FAIL reset_pulses: got %h want 0", {bus.ch_ack, bus.ch_done, bus.ch_err});
    end
    checks++;
    if ({bus.core_src, bus.core_dst, bus.core_len} !== 96'd0) begin
      failures++;
      $display("FAIL reset_desc: got %h want 0", {bus.core_src, bus.core_dst, bus.core_len});
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.core_power_on, bus.busy} !== 2'b00) begin
      failures++;
      $display("FAIL off_no_req: got %b want 00", {bus.core_power_on, bus.busy});
    end
    rr = 0;
  endtask

  task automatic test_wake_single_ch2();
    set_desc(2, 32'h1000, 32'h2000, 32'd16);
    bus.ch_req = 4'b0100;
    tick();
    checks++;
    if ({bus.core_power_on, bus.core_clk_en} !== 2'b10) begin
      failures++;
      $display("FAIL wake_power: got %b want 10", {bus.core_power_on, bus.core_clk_en});
    end
    repeat (WAKE - 1) tick();
    checks++;
    if (bus.core_clk_en !== 1'b0) begin
      failures++;
      $display("FAIL wake_clk_early: got %b want 0", bus.core_clk_en);
    end
    tick();
    checks++;
    if ({bus.core_clk_en, bus.core_start} !== 2'b10) begin
      failures++;
      $display("FAIL wake_clk_en: got %b want 10", {bus.core_clk_en, bus.core_start});
    end
    tick();
    checks++;
    if ({bus.core_start, bus.ch_ack} !== {1'b1, 4'b0100}) begin
      failures++;
      $display("FAIL ch2_issue: got %b want 10100", {bus.core_start, bus.ch_ack});
    end
    checks++;
    if ({bus.core_src, bus.core_dst, bus.core_len} !== {32'h1000, 32'h2000, 32'd16}) begin
      failures++;
      $display("FAIL ch2_desc: got %h want 00001000_00002000_00000010",
        {bus.core_src, bus.core_dst, bus.core_len});
    end
    bus.ch_req = '0;
    repeat (20) tick();
    checks++;
    if ({bus.busy, bus.core_src, bus.core_len} !== {1'b1, 32'h1000, 32'd16}) begin
      failures++;
      $display("FAIL ch2_run_stable: got %h", {bus.busy, bus.core_src, bus.core_len});
    end
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    checks++;
    if ({bus.ch_done, bus.ch_err} !== {4'b0100, 4'b0000}) begin
      failures++;
      $display("FAIL ch2_done: got %b want 01000000", {bus.ch_done, bus.ch_err});
    end
    rr = 3;
    tick();
  endtask

  task automatic test_zero_reject();
    int s;
    s = n_start;
    set_desc(1, $urandom(), $urandom(), 32'd0);
    bus.ch_req = 4'b0010;
    tick();
    checks++;
    if ({bus.ch_ack, bus.ch_done, bus.ch_err, bus.core_start} !== 13'b0010_0010_0000_0) begin
      failures++;
      $display("FAIL zero_len: got %b want 0010001000000",
        {bus.ch_ack, bus.ch_done, bus.ch_err, bus.core_start});
    end
    bus.ch_req = '0;
    tick();
    set_desc(1, $urandom(), $urandom(), 32'd6);
    bus.ch_req = 4'b0010;
    tick();
    checks++;
    if ({bus.ch_ack, bus.ch_done, bus.ch_err, bus.core_start} !== 13'b0010_0000_0010_0) begin
      failures++;
      $display("FAIL reject_len6: got %b want 0010000000100",
        {bus.ch_ack, bus.ch_done, bus.ch_err, bus.core_start});
    end
    bus.ch_req = '0;
    rr = 2;
    tick();
    checks++;
    if (n_start !== s) begin
      failures++;
      $display("FAIL zero_reject_nostart: got %0d starts want %0d", n_start, s);
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] mask;
    int g, d, r;
    for (int it = 0; it < 24; it++) begin
      mask = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int c = 0; c < NCH; c++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      set_desc(c, $urandom(), $urandom(), 32'd0);
        else if (r == 1) set_desc(c, $urandom(), $urandom(),
                           32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3)));
        else             set_desc(c, $urandom(), $urandom(),
                           32'($urandom_range(1, 1024) * 4));
      end
      bus.core_done = 1'b0;
      bus.ch_req = mask;
      tick();
      g = model_grant(mask, rr);
      checks++;
      if (bus.ch_ack !== oh(g)) begin
        failures++;
        $display("FAIL rand_ack it%0d: got %b want %b", it, bus.ch_ack, oh(g));
      end
      bus.ch_req = '0;
      if (lens[g] == 0) begin
        checks++;
        if ({bus.ch_done, bus.ch_err, bus.core_start} !== {oh(g), 4'b0, 1'b0}) begin
          failures++;
          $display("FAIL rand_zero it%0d: got %b", it, {bus.ch_done, bus.ch_err, bus.core_start});
        end
      end else if (lens[g] % 4 != 0) begin
        checks++;
        if ({bus.ch_done, bus.ch_err, bus.core_start} !== {4'b0, oh(g), 1'b0}) begin
          failures++;
          $display("FAIL rand_reject it%0d: got %b", it, {bus.ch_done, bus.ch_err, bus.core_start});
        end
      end else begin
        checks++;
        if ({bus.core_start, bus.core_src, bus.core_dst, bus.core_len}
            !== {1'b1, srcs[g], dsts[g], lens[g]}) begin
          failures++;
          $display("FAIL rand_issue it%0d: got %h want %h", it,
            {bus.core_start, bus.core_src, bus.core_dst, bus.core_len},
            {1'b1, srcs[g], dsts[g], lens[g]});
        end
        d = $urandom_range(1, 8);
        repeat (d) tick();
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        checks++;
        if ({bus.ch_done, bus.ch_err} !== {oh(g), 4'b0}) begin
          failures++;
          $display("FAIL rand_done it%0d: got %b want %b", it,
            {bus.ch_done, bus.ch_err}, {oh(g), 4'b0});
        end
      end
      rr = (g + 1) % NCH;
      // a stray core_done here lands outside RUN
      bus.core_done = 1'($urandom_range(0, 1));
      tick();
      bus.core_done = 1'b0;
    end
  endtask

  task automatic test_idle_timeout();
    int g;
    repeat (IDLE_TO - 1) tick();
    checks++;
    if ({bus.core_power_on, bus.core_clk_en} !== 2'b11) begin
      failures++;
      $display("FAIL idle_early: got %b want 11", {bus.core_power_on, bus.core_clk_en});
    end
    tick();
    checks++;
    if ({bus.core_power_on, bus.core_clk_en, bus.busy} !== 3'b000) begin
      failures++;
      $display("FAIL idle_off: got %b want 000", {bus.core_power_on, bus.core_clk_en, bus.busy});
    end
    repeat (3) tick();
    set_desc(0, 32'hA000, 32'hB000, 32'd64);
    bus.ch_req = 4'b0001;
    tick();
    checks++;
    if ({bus.core_power_on, bus.core_clk_en} !== 2'b10) begin
      failures++;
      $display("FAIL rewake_power: got %b want 10", {bus.core_power_on, bus.core_clk_en});
    end
    repeat (WAKE - 1) tick();
    checks++;
    if (bus.core_clk_en !== 1'b0) begin
      failures++;
      $display("FAIL rewake_clk_early: got %b want 0", bus.core_clk_en);
    end
    tick();
    checks++;
    if (bus.core_clk_en !== 1'b1) begin
      failures++;
      $display("FAIL rewake_clk_en: got %b want 1", bus.core_clk_en);
    end
    tick();
    g = model_grant(4'b0001, rr);
    checks++;
    if ({bus.core_start, bus.ch_ack} !== {1'b1, oh(g)}) begin
      failures++;
      $display("FAIL rewake_issue: got %b want %b", {bus.core_start, bus.ch_ack}, {1'b1, oh(g)});
    end
    bus.ch_req = '0;
    tick();
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    checks++;
    if (bus.ch_done !== oh(g)) begin
      failures++;
      $display("FAIL rewake_done: got %b want %b", bus.ch_done, oh(g));
    end
    rr = (g + 1) % NCH;
    tick();
  endtask

  task automatic test_watchdog();
    logic [NCH-1:0] mask;
    int g1, g2;
    mask = 4'b0110;
    for (int c = 0; c < NCH; c++)
      set_desc(c, $urandom(), $urandom(), 32'($urandom_range(1, 64) * 4));
    bus.ch_req = mask;
    tick();
    g1 = model_grant(mask, rr);
    checks++;
    if ({bus.core_start, bus.ch_ack} !== {1'b1, oh(g1)}) begin
      failures++;
      $display("FAIL wdog_issue: got %b want %b", {bus.core_start, bus.ch_ack}, {1'b1, oh(g1)});
    end
    mask = mask & ~oh(g1);
    bus.ch_req = mask;
    rr = (g1 + 1) % NCH;
    g2 = model_grant(mask, rr);
    repeat (WDOG) tick();
    checks++;
    if ({bus.ch_err, bus.core_power_on} !== {4'b0, 1'b1}) begin
      failures++;
      $display("FAIL wdog_early: got %b want 00001", {bus.ch_err, bus.core_power_on});
    end
    tick();
    checks++;
    if ({bus.ch_err, bus.ch_done, bus.core_power_on, bus.core_clk_en}
        !== {oh(g1), 4'b0, 2'b00}) begin
      failures++;
      $display("FAIL wdog_hung: got %b want %b",
        {bus.ch_err, bus.ch_done, bus.core_power_on, bus.core_clk_en}, {oh(g1), 4'b0, 2'b00});
    end
    tick();
    checks++;
    if ({bus.core_power_on, bus.core_clk_en, bus.busy, bus.ch_err} !== {3'b101, 4'b0}) begin
      failures++;
      $display("FAIL wdog_rewake: got %b want 1010000",
        {bus.core_power_on, bus.core_clk_en, bus.busy, bus.ch_err});
    end
    repeat (WAKE) tick();
    checks++;
    if (bus.core_clk_en !== 1'b1) begin
      failures++;
      $display("FAIL wdog_clk_en: got %b want 1", bus.core_clk_en);
    end
    tick();
    checks++;
    if ({bus.core_start, bus.ch_ack} !== {1'b1, oh(g2)}) begin
      failures++;
      $display("FAIL wdog_next: got %b want %b", {bus.core_start, bus.ch_ack}, {1'b1, oh(g2)});
    end
    bus.ch_req = '0;
    tick();
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    checks++;
    if (bus.ch_done !== oh(g2)) begin
      failures++;
      $display("FAIL wdog_next_done: got %b want %b", bus.ch_done, oh(g2));
    end
    rr = (g2 + 1) % NCH;
    tick();
  endtask

  task automatic test_round_robin();
    int s, w, g;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rr = 0;
    for (int c = 0; c < NCH; c++)
      set_desc(c, 32'h100 * c, 32'h8000 + c, 32'(32 * (c + 1)));
    bus.ch_req = 4'hF;
    s = n_ack;
    for (int n = 0; n < 5; n++) begin
      w = 0;
      while (bus.ch_ack === 4'b0 && w < 40) begin
        tick();
        w++;
      end
      g = model_grant(4'hF, rr);
      checks++;
      if (w >= 40) begin
        failures++;
        $display("FAIL rr_timeout xfer%0d: got no ack want %b", n, oh(g));
        break;
      end
      if ({bus.core_start, bus.ch_ack} !== {1'b1, oh(g)}) begin
        failures++;
        $display("FAIL rr_grant xfer%0d: got %b want %b", n,
          {bus.core_start, bus.ch_ack}, {1'b1, oh(g)});
      end
      tick();
      bus.core_done = 1'b1;
      tick();
      bus.core_done = 1'b0;
      checks++;
      if (bus.ch_done !== oh(g)) begin
        failures++;
        $display("FAIL rr_done xfer%0d: got %b want %b", n, bus.ch_done, oh(g));
      end
      rr = (g + 1) % NCH;
    end
    bus.ch_req = '0;
    checks++;
    if (n_ack - s !== 5) begin
      failures++;
      $display("FAIL rr_ack_count: got %0d want 5", n_ack - s);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int g, dn, de;
    set_desc(3, 32'hC000, 32'hD000, 32'd128);
    bus.ch_req = 4'b1000;
    tick();
    g = model_grant(4'b1000, rr);
    checks++;
    if (bus.ch_ack !== oh(g)) begin
      failures++;
      $display("FAIL midrst_ack: got %b want %b", bus.ch_ack, oh(g));
    end
    bus.ch_req = '0;
    repeat (5) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy: got %b want 1", bus.busy);
    end
    dn = n_done;
    de = n_err;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ch_ack, bus.ch_done, bus.ch_err, bus.busy, bus.core_start, bus.core_src,
         bus.core_dst, bus.core_len, bus.core_clk_en, bus.core_power_on} !== '0) begin
      failures++;
      $display("FAIL midrst_outs: got %h want 0",
        {bus.ch_ack, bus.ch_done, bus.ch_err, bus.busy, bus.core_start, bus.core_src,
         bus.core_dst, bus.core_len, bus.core_clk_en, bus.core_power_on});
    end
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    rst_n = 1'b1;
    repeat (10) tick();
    checks++;
    if ({n_done - dn, n_err - de} !== {32'd0, 32'd0}) begin
      failures++;
      $display("FAIL midrst_no_pulse: got done=%0d err=%0d want 0", n_done - dn, n_err - de);
    end
    checks++;
    if ({bus.core_power_on, bus.core_clk_en, bus.busy} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_off: got %b want 000",
        {bus.core_power_on, bus.core_clk_en, bus.busy});
    end
  endtask

  initial begin
    test_reset();
    test_wake_single_ch2();
    test_zero_reject();
    test_random();
    test_idle_timeout();
    test_watchdog();
    test_round_robin();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
